// File: rtl/mc_ctrl_pkg.sv
// Shared types for the multicycle control FSM: state encoding, opcodes and datapath select codes.
// Pure declarations; no timing or flow-control behaviour of its own.
package mc_ctrl_pkg;

    typedef enum logic [4:0] {
        S_RESET, S_FETCH, S_IR, S_DECODE, S_ADD, S_SUB, S_MOV, S_MUL, S_SAVE,
        S_LD_REQ, S_LD_WB, S_ST_REQ, S_BR, S_BR_IMM, S_CALL, S_CALL_WB, S_CALL_RX, S_TRAP
    } state_t;

    localparam int unsigned OP_MV   = 0;
    localparam int unsigned OP_ADD  = 1;
    localparam int unsigned OP_SUB  = 2;
    localparam int unsigned OP_CMP  = 3;
    localparam int unsigned OP_LD   = 4;
    localparam int unsigned OP_ST   = 5;
    localparam int unsigned OP_MVHI = 6;
    localparam int unsigned OP_MUL  = 7;
    localparam int unsigned OP_JR   = 8;
    localparam int unsigned OP_JZ   = 9;
    localparam int unsigned OP_JN   = 10;
    localparam int unsigned OP_CALL = 12;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_MUL  = 2'b10;
    localparam logic [1:0] ALUOP_PASS = 2'b11;

    localparam logic [1:0] ALU1_PC   = 2'b00;
    localparam logic [1:0] ALU1_RA   = 2'b01;
    localparam logic [1:0] ALU1_ZERO = 2'b11;

    localparam logic [1:0] ALU2_RB  = 2'b00;
    localparam logic [1:0] ALU2_ONE = 2'b01;
    localparam logic [1:0] ALU2_IMM = 2'b10;
    localparam logic [1:0] ALU2_ALT = 2'b11;

    function automatic logic br_taken(input int unsigned op, input logic n, input logic z);
        return (op == OP_JR) || (op == OP_JZ && z) || (op == OP_JN && n);
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory wait counter: counts non-ack request cycles, flags the cycle that would reach LIMIT.
// Timeout is combinational in the failing cycle; ack in that same cycle suppresses it.
module mc_wait_timer #(
    parameter int unsigned LIMIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic ack,
    output logic timeout
);
    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (active && !ack) begin
            cnt <= cnt + 8'd1;
        end else begin
            cnt <= '0;
        end
    end

    assign timeout = active && !ack && (cnt == 8'(LIMIT - 1));

endmodule

// File: rtl/mc_control_hs.sv
// Multicycle CPU control FSM with memory ack handshake, bounded wait, iterative MUL and traps.
// Strobes are combinational from state and inputs; memory stalls hold the request until ack or timeout.
module mc_control_hs
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned OPW         = 4,
    parameter int unsigned MUL_CYCLES  = 4,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [OPW-1:0] i_instr,
    input  logic           i_imm,
    input  logic           i_N,
    input  logic           i_Z,
    input  logic           i_mem_ack,
    output logic           o_PC_write,
    output logic           o_Addr_sel,
    output logic           o_mem_rd,
    output logic           o_mem_wr,
    output logic           o_MDR_load,
    output logic           o_IR_load,
    output logic           o_OpA_sel,
    output logic           o_OpAB_load,
    output logic           o_ALU_out,
    output logic           o_RF_write,
    output logic           o_RF_write_call,
    output logic           o_Reg_in,
    output logic           o_Flag_write,
    output logic           o_mov_hi,
    output logic [1:0]     o_ALU_1_sel,
    output logic [1:0]     o_ALU_2_sel,
    output logic [1:0]     o_ALUop_sel,
    output logic           o_mul_step,
    output logic           o_busy,
    output logic           o_illegal,
    output logic           o_mem_err
);
    state_t      state, state_nxt;
    logic [7:0]  mul_cnt;
    logic        mul_last;
    logic        wait_active, timeout;
    logic        illegal_set, mem_err_set;
    int unsigned op;

    assign op          = 32'(i_instr);
    assign mul_last    = (mul_cnt == 8'(MUL_CYCLES - 1));
    assign wait_active = (state == S_FETCH) || (state == S_LD_REQ) || (state == S_ST_REQ);

    mc_wait_timer #(.LIMIT(MEM_TIMEOUT)) u_wait (
        .clk     (clk),
        .rst     (rst),
        .active  (wait_active),
        .ack     (i_mem_ack),
        .timeout (timeout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_RESET;
            mul_cnt   <= '0;
            o_illegal <= 1'b0;
            o_mem_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            mul_cnt   <= (state == S_MUL && !mul_last) ? mul_cnt + 8'd1 : 8'd0;
            o_illegal <= o_illegal | illegal_set;
            o_mem_err <= o_mem_err | mem_err_set;
        end
    end

    always_comb begin
        state_nxt       = state;
        illegal_set     = 1'b0;
        mem_err_set     = 1'b0;
        o_PC_write      = 1'b0;
        o_Addr_sel      = 1'b0;
        o_mem_rd        = 1'b0;
        o_mem_wr        = 1'b0;
        o_MDR_load      = 1'b0;
        o_IR_load       = 1'b0;
        o_OpA_sel       = 1'b0;
        o_OpAB_load     = 1'b0;
        o_ALU_out       = 1'b0;
        o_RF_write      = 1'b0;
        o_RF_write_call = 1'b0;
        o_Reg_in        = 1'b0;
        o_Flag_write    = 1'b0;
        o_mov_hi        = 1'b0;
        o_ALU_1_sel     = ALU1_PC;
        o_ALU_2_sel     = ALU2_RB;
        o_ALUop_sel     = ALUOP_ADD;
        o_mul_step      = 1'b0;
        o_busy          = (state != S_FETCH) && (state != S_RESET);

        unique case (state)
            S_RESET: state_nxt = S_FETCH;
            S_FETCH: begin
                o_mem_rd    = 1'b1;
                o_Addr_sel  = 1'b1;
                o_ALU_2_sel = ALU2_ONE;
                if (i_mem_ack) begin
                    o_PC_write = 1'b1;
                    state_nxt  = S_IR;
                end else if (timeout) begin
                    mem_err_set = 1'b1;
                    state_nxt   = S_TRAP;
                end
            end
            S_IR: begin
                o_IR_load = 1'b1;
                state_nxt = S_DECODE;
            end
            S_DECODE: begin
                o_OpAB_load = 1'b1;
                case (op)
                    OP_MV, OP_MVHI:   state_nxt = S_MOV;
                    OP_ADD:           state_nxt = S_ADD;
                    OP_SUB, OP_CMP:   state_nxt = S_SUB;
                    OP_LD:            state_nxt = S_LD_REQ;
                    OP_ST:            state_nxt = S_ST_REQ;
                    OP_MUL:           state_nxt = S_MUL;
                    OP_JR, OP_JZ, OP_JN: state_nxt = S_BR;
                    OP_CALL:          state_nxt = S_CALL;
                    default: begin
                        illegal_set = 1'b1;
                        state_nxt   = S_TRAP;
                    end
                endcase
            end
            S_ADD, S_SUB: begin
                o_ALU_1_sel  = ALU1_RA;
                o_ALU_2_sel  = i_imm ? ALU2_IMM : ALU2_RB;
                o_ALUop_sel  = (state == S_SUB) ? ALUOP_SUB : ALUOP_ADD;
                o_ALU_out    = 1'b1;
                o_Flag_write = 1'b1;
                state_nxt    = (state == S_SUB && op == OP_CMP) ? S_FETCH : S_SAVE;
            end
            S_MOV: begin
                if (op == OP_MV) begin
                    o_ALU_1_sel = ALU1_ZERO;
                    o_ALU_2_sel = i_imm ? ALU2_IMM : ALU2_RB;
                    o_ALU_out   = 1'b1;
                    state_nxt   = S_SAVE;
                end else if (i_imm) begin
                    o_mov_hi  = 1'b1;
                    o_ALU_out = 1'b1;
                    state_nxt = S_SAVE;
                end else begin
                    state_nxt = S_FETCH;
                end
            end
            S_MUL: begin
                o_ALUop_sel = ALUOP_MUL;
                o_ALU_2_sel = ALU2_ALT;
                o_mul_step  = 1'b1;
                if (mul_last) begin
                    o_ALU_out    = 1'b1;
                    o_Flag_write = 1'b1;
                    state_nxt    = S_SAVE;
                end
            end
            S_SAVE: begin
                o_RF_write = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_LD_REQ: begin
                o_mem_rd = 1'b1;
                if (i_mem_ack) begin
                    o_MDR_load = 1'b1;
                    state_nxt  = S_LD_WB;
                end else if (timeout) begin
                    mem_err_set = 1'b1;
                    state_nxt   = S_TRAP;
                end
            end
            S_LD_WB: begin
                o_ALU_out  = 1'b1;
                o_Reg_in   = 1'b1;
                o_RF_write = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_ST_REQ: begin
                o_mem_wr = 1'b1;
                if (i_mem_ack) begin
                    state_nxt = S_FETCH;
                end else if (timeout) begin
                    mem_err_set = 1'b1;
                    state_nxt   = S_TRAP;
                end
            end
            S_BR: begin
                if (!br_taken(op, i_N, i_Z)) begin
                    state_nxt = S_FETCH;
                end else if (i_imm) begin
                    state_nxt = S_BR_IMM;
                end else begin
                    o_PC_write  = 1'b1;
                    o_ALU_1_sel = ALU1_RA;
                    o_ALUop_sel = ALUOP_PASS;
                    state_nxt   = S_FETCH;
                end
            end
            S_BR_IMM: begin
                o_PC_write  = 1'b1;
                o_ALU_2_sel = ALU2_ALT;
                o_ALU_out   = 1'b1;
                state_nxt   = S_FETCH;
            end
            S_CALL: begin
                o_ALUop_sel = ALUOP_PASS;
                o_ALU_out   = 1'b1;
                state_nxt   = S_CALL_WB;
            end
            S_CALL_WB: begin
                o_RF_write      = 1'b1;
                o_RF_write_call = 1'b1;
                state_nxt       = i_imm ? S_BR_IMM : S_CALL_RX;
            end
            S_CALL_RX: begin
                o_PC_write  = 1'b1;
                o_ALU_1_sel = ALU1_RA;
                state_nxt   = S_FETCH;
            end
            S_TRAP:  state_nxt = S_TRAP;
            default: state_nxt = S_RESET;
        endcase
    end

endmodule

// File: tb/tb_mc_control_hs.sv
// Bench for mc_control_hs: per-instruction cycle schedules built from the instruction rules,
// compared cycle by cycle against the DUT under a memory that acks after a chosen delay.
module tb_mc_control_hs;
    localparam int OPW  = 4;
    localparam int MULC = 4;
    localparam int TMO  = 15;

    typedef struct packed {
        logic       pc_write, addr_sel, mem_rd, mem_wr, mdr_load, ir_load, opa_sel, opab_load;
        logic       alu_out, rf_write, rf_write_call, reg_in, flag_write, mov_hi;
        logic [1:0] alu1, alu2, aluop;
        logic       mul_step, busy, illegal, mem_err;
    } ov_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [OPW-1:0] i_instr = '0;
    logic i_imm = 1'b0, i_N = 1'b0, i_Z = 1'b0, i_mem_ack = 1'b0;
    logic o_PC_write, o_Addr_sel, o_mem_rd, o_mem_wr, o_MDR_load, o_IR_load, o_OpA_sel;
    logic o_OpAB_load, o_ALU_out, o_RF_write, o_RF_write_call, o_Reg_in, o_Flag_write, o_mov_hi;
    logic [1:0] o_ALU_1_sel, o_ALU_2_sel, o_ALUop_sel;
    logic o_mul_step, o_busy, o_illegal, o_mem_err;

    int  total = 0;
    int  bad   = 0;
    ov_t exp_q[$];
    ov_t obs_q[$];
    int  dly_q[$];
    int  wcnt;
    bit  m_ill, m_merr;

    always #5 clk = ~clk;

    mc_control_hs #(.OPW(OPW), .MUL_CYCLES(MULC), .MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .i_instr(i_instr), .i_imm(i_imm), .i_N(i_N), .i_Z(i_Z),
        .i_mem_ack(i_mem_ack), .o_PC_write(o_PC_write), .o_Addr_sel(o_Addr_sel),
        .o_mem_rd(o_mem_rd), .o_mem_wr(o_mem_wr), .o_MDR_load(o_MDR_load), .o_IR_load(o_IR_load),
        .o_OpA_sel(o_OpA_sel), .o_OpAB_load(o_OpAB_load), .o_ALU_out(o_ALU_out),
        .o_RF_write(o_RF_write), .o_RF_write_call(o_RF_write_call), .o_Reg_in(o_Reg_in),
        .o_Flag_write(o_Flag_write), .o_mov_hi(o_mov_hi), .o_ALU_1_sel(o_ALU_1_sel),
        .o_ALU_2_sel(o_ALU_2_sel), .o_ALUop_sel(o_ALUop_sel), .o_mul_step(o_mul_step),
        .o_busy(o_busy), .o_illegal(o_illegal), .o_mem_err(o_mem_err)
    );

    function automatic ov_t obs();
        ov_t c;
        c = {o_PC_write, o_Addr_sel, o_mem_rd, o_mem_wr, o_MDR_load, o_IR_load, o_OpA_sel,
             o_OpAB_load, o_ALU_out, o_RF_write, o_RF_write_call, o_Reg_in, o_Flag_write,
             o_mov_hi, o_ALU_1_sel, o_ALU_2_sel, o_ALUop_sel, o_mul_step, o_busy,
             o_illegal, o_mem_err};
        return c;
    endfunction

    function automatic ov_t idle();
        ov_t c = '0;
        c.busy    = 1'b1;
        c.illegal = m_ill;
        c.mem_err = m_merr;
        return c;
    endfunction

    // kind: 0 fetch, 1 load, 2 store; d = wait cycles before ack (>= TMO means never)
    task automatic m_req(input int kind, input int d, output bit trap);
        ov_t c;
        trap = 1'b0;
        for (int i = 0; i < TMO && i <= d; i++) begin
            c = idle();
            if (kind == 0) begin
                c.busy = 1'b0; c.mem_rd = 1'b1; c.addr_sel = 1'b1; c.alu2 = 2'b01;
                if (i == d) c.pc_write = 1'b1;
            end else if (kind == 1) begin
                c.mem_rd = 1'b1;
                if (i == d) c.mdr_load = 1'b1;
            end else begin
                c.mem_wr = 1'b1;
            end
            exp_q.push_back(c);
        end
        if (d >= TMO) begin
            trap   = 1'b1;
            m_merr = 1'b1;
        end
    endtask

    task automatic m_save();
        ov_t c = idle();
        c.rf_write = 1'b1;
        exp_q.push_back(c);
    endtask

    task automatic m_brimm();
        ov_t c = idle();
        c.pc_write = 1'b1; c.alu2 = 2'b11; c.alu_out = 1'b1;
        exp_q.push_back(c);
    endtask

    task automatic plan(input int op, input bit imm, input bit n, input bit z,
                        input int df, input int dm, input int ntrap);
        ov_t c;
        bit  tr;
        bit  taken;
        dly_q.push_back(df);
        if (op == 4 || op == 5) dly_q.push_back(dm);
        m_req(0, df, tr);
        if (!tr) begin
            c = idle(); c.ir_load = 1'b1;   exp_q.push_back(c);
            c = idle(); c.opab_load = 1'b1; exp_q.push_back(c);
            case (op)
                1, 2, 3: begin
                    c = idle(); c.alu1 = 2'b01; c.alu2 = imm ? 2'b10 : 2'b00;
                    c.alu_out = 1'b1; c.flag_write = 1'b1;
                    if (op != 1) c.aluop = 2'b01;
                    exp_q.push_back(c);
                    if (op != 3) m_save();
                end
                0: begin
                    c = idle(); c.alu1 = 2'b11; c.alu2 = imm ? 2'b10 : 2'b00; c.alu_out = 1'b1;
                    exp_q.push_back(c);
                    m_save();
                end
                6: begin
                    c = idle();
                    if (imm) begin c.mov_hi = 1'b1; c.alu_out = 1'b1; end
                    exp_q.push_back(c);
                    if (imm) m_save();
                end
                7: begin
                    for (int k = 0; k < MULC; k++) begin
                        c = idle(); c.aluop = 2'b10; c.alu2 = 2'b11; c.mul_step = 1'b1;
                        if (k == MULC - 1) begin c.alu_out = 1'b1; c.flag_write = 1'b1; end
                        exp_q.push_back(c);
                    end
                    m_save();
                end
                4: begin
                    m_req(1, dm, tr);
                    if (!tr) begin
                        c = idle(); c.alu_out = 1'b1; c.reg_in = 1'b1; c.rf_write = 1'b1;
                        exp_q.push_back(c);
                    end
                end
                5: m_req(2, dm, tr);
                8, 9, 10: begin
                    taken = (op == 8) || (op == 9 && z) || (op == 10 && n);
                    c = idle();
                    if (taken && !imm) begin c.pc_write = 1'b1; c.alu1 = 2'b01; c.aluop = 2'b11; end
                    exp_q.push_back(c);
                    if (taken && imm) m_brimm();
                end
                12: begin
                    c = idle(); c.aluop = 2'b11; c.alu_out = 1'b1; exp_q.push_back(c);
                    c = idle(); c.rf_write = 1'b1; c.rf_write_call = 1'b1; exp_q.push_back(c);
                    if (imm) m_brimm();
                    else begin c = idle(); c.pc_write = 1'b1; c.alu1 = 2'b01; exp_q.push_back(c); end
                end
                default: begin
                    tr    = 1'b1;
                    m_ill = 1'b1;
                end
            endcase
        end
        if (tr) repeat (ntrap) exp_q.push_back(idle());
    endtask

    // Drives one instruction's inputs and plays a memory that acks after the queued delay.
    task automatic run(input int ncyc, input int op, input bit imm, input bit n, input bit z);
        bit req;
        obs_q.delete();
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (i == 0) begin
                i_instr = op[OPW-1:0]; i_imm = imm; i_N = n; i_Z = z;
            end
            req = o_mem_rd | o_mem_wr;
            i_mem_ack = req && (wcnt == ((dly_q.size() > 0) ? dly_q[0] : 0));
            #1;
            obs_q.push_back(obs());
            if (req) begin
                if (i_mem_ack) begin
                    wcnt = 0;
                    if (dly_q.size() > 0) void'(dly_q.pop_front());
                end else begin
                    wcnt++;
                end
            end
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1; i_instr = '0; i_imm = 1'b0; i_N = 1'b0; i_Z = 1'b0; i_mem_ack = 1'b0;
        dly_q.delete(); exp_q.delete(); wcnt = 0; m_ill = 1'b0; m_merr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        ov_t f;
        reset_dut();
        total++;
        if (obs() !== '0) begin bad++; $display("FAIL reset_state got=%h exp=0", obs()); end
        plan(7, 0, 0, 0, 0, 0, 0);
        run(5, 7, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1; i_mem_ack = 1'b0;
        #1;
        total++;
        if (o_mul_step !== 1'b1 || o_ALU_out !== 1'b0) begin
            bad++; $display("FAIL mid_mul_step got=%b%b exp=10", o_mul_step, o_ALU_out);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (obs() !== '0) begin bad++; $display("FAIL rst_mid_mul got=%h exp=0", obs()); end
        @(negedge clk);
        #1;
        f = '0; f.mem_rd = 1'b1; f.addr_sel = 1'b1; f.alu2 = 2'b01;
        total++;
        if (obs() !== f) begin bad++; $display("FAIL fetch_after_rst got=%h exp=%h", obs(), f); end
    endtask

    task automatic test_add_imm();
        int pcw = 0;
        reset_dut();
        plan(1, 1, 0, 0, 0, 0, 0);
        plan(1, 1, 0, 0, 0, 0, 0);
        run(exp_q.size(), 1, 1, 0, 0);
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL add_imm cyc=%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
            end
            if (i < 5) pcw += int'(obs_q[i].pc_write);
        end
        total++;
        if (pcw != 1) begin bad++; $display("FAIL add_pc_write_count got=%0d exp=1", pcw); end
    endtask

    task automatic test_fetch_wait();
        reset_dut();
        plan(1, 0, 0, 0, 3, 0, 0);
        run(exp_q.size(), 1, 0, 0, 0);
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL fetch_wait cyc=%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
            end
        end
        total++;
        if (obs_q[3].pc_write !== 1'b1 || obs_q[2].pc_write !== 1'b0) begin
            bad++; $display("FAIL fetch_wait_pcw got=%b%b exp=01", obs_q[2].pc_write, obs_q[3].pc_write);
        end
    endtask

    task automatic test_timeout();
        reset_dut();
        plan(1, 0, 0, 0, 99, 0, 6);
        run(exp_q.size(), 1, 0, 0, 0);
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL fetch_timeout cyc=%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (o_mem_err !== 1'b0 || obs() !== '0) begin
            bad++; $display("FAIL mem_err_cleared got=%h exp=0", obs());
        end
    endtask

    task automatic test_mul();
        int steps = 0;
        reset_dut();
        plan(7, 0, 0, 0, 0, 0, 0);
        run(exp_q.size(), 7, 0, 0, 0);
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL mul cyc=%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
            end
            steps += int'(obs_q[i].mul_step);
        end
        total++;
        if (steps != MULC) begin bad++; $display("FAIL mul_step_count got=%0d exp=%0d", steps, MULC); end
    endtask

    task automatic test_branch_call();
        int tbl[6][4] = '{'{9, 0, 0, 0}, '{9, 1, 0, 1}, '{10, 0, 1, 0},
                          '{8, 0, 0, 0}, '{12, 0, 0, 0}, '{12, 1, 0, 0}};
        reset_dut();
        for (int t = 0; t < 6; t++) begin
            exp_q.delete();
            plan(tbl[t][0], tbl[t][1] != 0, tbl[t][2] != 0, tbl[t][3] != 0, t % 3, 0, 0);
            run(exp_q.size(), tbl[t][0], tbl[t][1] != 0, tbl[t][2] != 0, tbl[t][3] != 0);
            for (int i = 0; i < exp_q.size(); i++) begin
                total++;
                if (obs_q[i] !== exp_q[i]) begin
                    bad++; $display("FAIL branch_call op=%0d cyc=%0d got=%h exp=%h",
                                    tbl[t][0], i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_illegal();
        int ill[2] = '{15, 11};
        for (int t = 0; t < 2; t++) begin
            reset_dut();
            plan(ill[t], 1, 0, 0, 0, 0, 5);
            run(exp_q.size(), ill[t], 1, 0, 0);
            for (int i = 0; i < exp_q.size(); i++) begin
                total++;
                if (obs_q[i] !== exp_q[i]) begin
                    bad++; $display("FAIL illegal op=%0d cyc=%0d got=%h exp=%h", ill[t], i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_mem_edge();
        int tbl[3][2] = '{'{4, 14}, '{5, 14}, '{4, 15}};
        reset_dut();
        for (int t = 0; t < 3; t++) begin
            exp_q.delete();
            plan(tbl[t][0], 0, 0, 0, 0, tbl[t][1], 4);
            run(exp_q.size(), tbl[t][0], 0, 0, 0);
            for (int i = 0; i < exp_q.size(); i++) begin
                total++;
                if (obs_q[i] !== exp_q[i]) begin
                    bad++; $display("FAIL mem_edge op=%0d d=%0d cyc=%0d got=%h exp=%h",
                                    tbl[t][0], tbl[t][1], i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        int  ops[12] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 12};
        int  op;
        bit  imm, n, z;
        reset_dut();
        for (int t = 0; t < 40; t++) begin
            op  = ops[$urandom_range(0, 11)];
            imm = 1'($urandom_range(0, 1));
            n   = 1'($urandom_range(0, 1));
            z   = 1'($urandom_range(0, 1));
            exp_q.delete();
            plan(op, imm, n, z, $urandom_range(0, 3), $urandom_range(0, 4), 0);
            run(exp_q.size(), op, imm, n, z);
            for (int i = 0; i < exp_q.size(); i++) begin
                total++;
                if (obs_q[i] !== exp_q[i]) begin
                    bad++; $display("FAIL random t=%0d op=%0d cyc=%0d got=%h exp=%h", t, op, i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_add_imm();
        test_fetch_wait();
        test_timeout();
        test_mul();
        test_branch_call();
        test_illegal();
        test_mem_edge();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
